// File: rtl/float_conv.sv
// float_conv -- sequential converter between two's-complement integers and
// IEEE-style binary floating point of the same total width.
//
// A conversion is requested in Ready by pulsing in_start; the operand and
// operation are captured and the FSM then normalises or shifts the magnitude
// one bit per cycle. Results are truncated (never rounded). Float-to-int
// saturates out-of-range inputs, infinities and NaNs and flags out_overflow.
//
// Ports:
//   in_clk        sole clock, rising edge
//   in_rst        synchronous reset, active low
//   in_start      start request, only looked at in Ready
//   in_op         0 = signed int -> float, 1 = float -> signed int
//   in_val        operand (integer or {sign, exp, mant})
//   out_val       result, held until the next conversion completes
//   out_overflow  saturation flag belonging to out_val
//   out_ready     high exactly while the FSM sits in Ready
module float_conv #(
    parameter int BITS      = 32,
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = BITS - EXP_BITS - 1,
    parameter int EXP_BIAS  = (1 << (EXP_BITS - 1)) - 1
) (
    input  logic            in_clk,
    input  logic            in_rst,
    input  logic            in_start,
    input  logic            in_op,
    input  logic [BITS-1:0] in_val,
    output logic [BITS-1:0] out_val,
    output logic            out_overflow,
    output logic            out_ready
);

    // Two spare bits so the unbiased exponent and the shift distance are
    // representable as signed values for any exponent field.
    localparam int EW = EXP_BITS + 2;
    localparam int CW = $clog2(BITS) + 1;

    typedef enum logic [2:0] {
        ST_READY,
        ST_LOAD,
        ST_NORM_OVER,
        ST_NORM_UNDER,
        ST_SHIFT,
        ST_SIGN
    } state_t;

    state_t                state_q;
    logic                  op_q;
    logic [BITS-1:0]       val_q;
    logic                  sign_q;
    logic [EXP_BITS-1:0]   exp_q;
    logic [BITS:0]         mag_q;
    logic [CW-1:0]         cnt_q;
    logic                  left_q;
    logic [BITS-1:0]       out_val_q;
    logic                  ovf_q;
    logic                  ready_q;

    // Decode of the captured operand, valid while in Load.
    logic                  f_sign;
    logic [EXP_BITS-1:0]   f_exp;
    logic [MANT_BITS-1:0]  f_mant;
    logic signed [EW-1:0]  f_e;
    logic signed [EW-1:0]  f_diff;
    logic signed [EW-1:0]  f_abs;
    logic                  f_left;
    logic                  f_zero;
    logic                  f_ovf;
    logic [CW-1:0]         f_cnt;
    logic [BITS:0]         i_ext;
    logic [BITS:0]         mag_d;

    // Saturated integer for an out-of-range float of the given sign.
    function automatic logic [BITS-1:0] sat_int(input logic sign);
        return sign ? {1'b1, {(BITS-1){1'b0}}} : {1'b0, {(BITS-1){1'b1}}};
    endfunction

    // Two's-complement result from sign and magnitude.
    function automatic logic [BITS-1:0] apply_sign(input logic sign,
                                                   input logic [BITS-1:0] mag);
        return sign ? (~mag + BITS'(1)) : mag;
    endfunction

    always_comb begin
        f_sign = val_q[BITS-1];
        f_exp  = val_q[BITS-2:MANT_BITS];
        f_mant = val_q[MANT_BITS-1:0];
        f_e    = $signed({2'b00, f_exp}) - $signed(EW'(EXP_BIAS));
        f_diff = f_e - $signed(EW'(MANT_BITS));
        f_left = !f_diff[EW-1] && (f_diff != '0);
        f_abs  = f_diff[EW-1] ? -f_diff : f_diff;
        f_cnt  = CW'(f_abs);
        f_zero = (f_exp == '0) || f_e[EW-1];
        f_ovf  = (&f_exp) || (f_e >= $signed(EW'(BITS - 1)));
        // Sign-extend by one bit before negating so the most negative
        // integer yields its exact magnitude.
        i_ext  = {val_q[BITS-1], val_q};
        mag_d  = i_ext[BITS] ? (~i_ext + (BITS+1)'(1)) : i_ext;
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst) begin
            state_q   <= ST_READY;
            op_q      <= 1'b0;
            val_q     <= '0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            mag_q     <= '0;
            cnt_q     <= '0;
            left_q    <= 1'b0;
            out_val_q <= '0;
            ovf_q     <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            case (state_q)
                ST_READY: begin
                    if (in_start) begin
                        val_q   <= in_val;
                        op_q    <= in_op;
                        state_q <= ST_LOAD;
                        ready_q <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    if (!op_q) begin
                        sign_q <= val_q[BITS-1];
                        mag_q  <= mag_d;
                        // Magnitude starts as an integer with the binary
                        // point just below bit 0 of the mantissa field.
                        exp_q  <= EXP_BITS'(EXP_BIAS + MANT_BITS);
                        if (mag_d == '0) begin
                            out_val_q <= '0;
                            ovf_q     <= 1'b0;
                            state_q   <= ST_READY;
                            ready_q   <= 1'b1;
                        end else begin
                            state_q <= ST_NORM_OVER;
                        end
                    end else begin
                        sign_q <= f_sign;
                        if (f_zero) begin
                            out_val_q <= '0;
                            ovf_q     <= 1'b0;
                            state_q   <= ST_READY;
                            ready_q   <= 1'b1;
                        end else if (f_ovf) begin
                            out_val_q <= sat_int(f_sign);
                            ovf_q     <= 1'b1;
                            state_q   <= ST_READY;
                            ready_q   <= 1'b1;
                        end else begin
                            mag_q   <= {{(BITS-MANT_BITS){1'b0}}, 1'b1, f_mant};
                            cnt_q   <= f_cnt;
                            left_q  <= f_left;
                            state_q <= (f_cnt == '0) ? ST_SIGN : ST_SHIFT;
                        end
                    end
                end

                ST_NORM_OVER: begin
                    // Anything above the hidden-bit position must be shifted
                    // out; the bits dropped at the bottom are truncated.
                    if (|mag_q[BITS:MANT_BITS+1]) begin
                        mag_q <= mag_q >> 1;
                        exp_q <= exp_q + EXP_BITS'(1);
                    end else begin
                        state_q <= ST_NORM_UNDER;
                    end
                end

                ST_NORM_UNDER: begin
                    if (!mag_q[MANT_BITS]) begin
                        mag_q <= mag_q << 1;
                        exp_q <= exp_q - EXP_BITS'(1);
                    end else begin
                        out_val_q <= {sign_q, exp_q, mag_q[MANT_BITS-1:0]};
                        ovf_q     <= 1'b0;
                        state_q   <= ST_READY;
                        ready_q   <= 1'b1;
                    end
                end

                ST_SHIFT: begin
                    mag_q <= left_q ? (mag_q << 1) : (mag_q >> 1);
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= ST_SIGN;
                    end
                end

                ST_SIGN: begin
                    out_val_q <= apply_sign(sign_q, mag_q[BITS-1:0]);
                    ovf_q     <= 1'b0;
                    state_q   <= ST_READY;
                    ready_q   <= 1'b1;
                end

                default: begin
                    state_q <= ST_READY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign out_val      = out_val_q;
    assign out_overflow = ovf_q;
    assign out_ready    = ready_q;

endmodule

// File: tb/tb_float_conv.sv
// tb_float_conv -- directed, table-driven bench for float_conv (32-bit).
// Each vector gives operation, operand, expected result, expected overflow
// flag and the edge number (sampling edge counted as 1) on which out_ready
// returns high. Hand-written sequences cover reset and the start handshake.
module tb_float_conv;

    logic        in_clk = 1'b0;
    logic        in_rst = 1'b0;
    logic        in_start = 1'b0;
    logic        in_op = 1'b0;
    logic [31:0] in_val = '0;
    logic [31:0] out_val;
    logic        out_overflow;
    logic        out_ready;

    int checks = 0;
    int failures = 0;

    float_conv dut (
        .in_clk      (in_clk),
        .in_rst      (in_rst),
        .in_start    (in_start),
        .in_op       (in_op),
        .in_val      (in_val),
        .out_val     (out_val),
        .out_overflow(out_overflow),
        .out_ready   (out_ready)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        logic        op;
        logic [31:0] val;
        logic [31:0] res;
        logic        ovf;
        int          edges;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge in_clk);
        #1;
    endtask

    task automatic run(input string name, input logic op, input logic [31:0] v,
                       input logic [31:0] ev, input logic eo, input int ee);
        logic [31:0] prev;
        logic        held;
        int          k;
        prev = out_val;
        held = 1'b1;
        in_op = op;
        in_val = v;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        in_val = 32'hDEADBEEF;
        chk({name, "_busy"}, {31'b0, out_ready}, 32'd0);
        k = 1;
        while (!out_ready && k < 64) begin
            if (out_val !== prev) held = 1'b0;
            tick();
            k++;
        end
        chk({name, "_lat"}, 32'(k), 32'(ee));
        chk({name, "_val"}, out_val, ev);
        chk({name, "_ovf"}, {31'b0, out_overflow}, {31'b0, eo});
        chk({name, "_hold"}, {31'b0, held}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] prev;
        logic        held;
        int          k;

        vecs = '{
            '{1'b0, 32'h00000001, 32'h3F800000, 1'b0, 27},
            '{1'b0, 32'h80000000, 32'hCF000000, 1'b0, 12},
            '{1'b0, 32'h01000001, 32'h4B800000, 1'b0, 5},
            '{1'b0, 32'h00000000, 32'h00000000, 1'b0, 2},
            '{1'b0, 32'h00000005, 32'h40A00000, 1'b0, 25},
            '{1'b0, 32'hFFFFFFFF, 32'hBF800000, 1'b0, 27},
            '{1'b1, 32'h40490FDB, 32'h00000003, 1'b0, 25},
            '{1'b1, 32'hC0490FDB, 32'hFFFFFFFD, 1'b0, 25},
            '{1'b1, 32'h3F000000, 32'h00000000, 1'b0, 2},
            '{1'b1, 32'h4B000001, 32'h00800001, 1'b0, 3},
            '{1'b1, 32'h4E800000, 32'h40000000, 1'b0, 10},
            '{1'b1, 32'h00000001, 32'h00000000, 1'b0, 2},
            '{1'b1, 32'h4F000000, 32'h7FFFFFFF, 1'b1, 2},
            '{1'b1, 32'hFF800000, 32'h80000000, 1'b1, 2},
            '{1'b1, 32'h3F800000, 32'h00000001, 1'b0, 26},
            '{1'b1, 32'hCF000000, 32'h80000000, 1'b1, 2},
            '{1'b1, 32'h7F800000, 32'h7FFFFFFF, 1'b1, 2}
        };

        // Power-on reset.
        in_rst = 1'b0;
        tick();
        tick();
        chk("rst_ready", {31'b0, out_ready}, 32'd1);
        chk("rst_val", out_val, 32'h0);
        chk("rst_ovf", {31'b0, out_overflow}, 32'd0);
        in_rst = 1'b1;
        tick();

        for (int i = 0; i < 17; i++) begin
            run($sformatf("vec%0d", i), vecs[i].op, vecs[i].val, vecs[i].res,
                vecs[i].ovf, vecs[i].edges);
        end

        // Reset in the middle of a conversion; last result was saturated.
        in_op = 1'b0;
        in_val = 32'h00000001;
        in_start = 1'b1;
        tick();
        in_start = 1'b0;
        repeat (5) tick();
        chk("midrst_busy", {31'b0, out_ready}, 32'd0);
        in_rst = 1'b0;
        in_start = 1'b1;
        in_val = 32'h00000005;
        tick();
        chk("midrst_ready", {31'b0, out_ready}, 32'd1);
        chk("midrst_val", out_val, 32'h0);
        chk("midrst_ovf", {31'b0, out_overflow}, 32'd0);
        in_rst = 1'b1;
        in_start = 1'b0;
        tick();
        chk("midrst_idle", {31'b0, out_ready}, 32'd1);
        run("postrst", 1'b0, 32'h00000005, 32'h40A00000, 1'b0, 25);

        // Start held high with operand toggling while busy.
        prev = out_val;
        held = 1'b1;
        in_op = 1'b1;
        in_val = 32'h40490FDB;
        in_start = 1'b1;
        tick();
        k = 1;
        while (!out_ready && k < 64) begin
            if (out_val !== prev) held = 1'b0;
            in_val = ~in_val;
            in_op = ~in_op;
            tick();
            k++;
        end
        chk("hs_lat", 32'(k), 32'd25);
        chk("hs_val", out_val, 32'h00000003);
        chk("hs_hold", {31'b0, held}, 32'd1);
        in_op = 1'b1;
        in_val = 32'h4B000001;
        tick();
        chk("hs_accept", {31'b0, out_ready}, 32'd0);
        in_start = 1'b0;
        k = 1;
        while (!out_ready && k < 64) begin
            tick();
            k++;
        end
        chk("hs2_lat", 32'(k), 32'd3);
        chk("hs2_val", out_val, 32'h00800001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
